// File: rtl/sum_result_fifo_if.sv
// Result handshake bundle between adder, FIFO and consumer.
// slave = FIFO side, master = producer/consumer side.
interface sum_result_fifo_if #(
    parameter int W = 10
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/sum_result_fifo.sv
// Result FIFO: buffers adder result pulses, drops and counts on full.
// Optional running total of popped data under `SUMFIFO_TOTAL_EN.
module sum_result_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sum_result_fifo_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    input  logic                       ovf_clr,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
`ifdef SUMFIFO_TOTAL_EN
    ,
    output logic [W+7:0]               total
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_diff;

    assign w_pop  = !r_empty & bus.out_ready;
    assign w_push = bus.in_valid & (!r_full | w_pop);
    assign w_drop = bus.in_valid & r_full & !w_pop;

    // Next pointer values and the occupancy they imply.
    always_comb begin
        w_wr_nxt = r_wr_ptr;
        w_rd_nxt = r_rd_ptr;
        if (w_push) w_wr_nxt = r_wr_ptr + PW'(1);
        if (w_pop)  w_rd_nxt = r_rd_ptr + PW'(1);
        w_diff = w_wr_nxt - w_rd_nxt;
    end

    // Pointers and registered status, updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= CW'(w_diff);
            r_empty  <= (w_wr_nxt == w_rd_nxt);
            r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                        (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
        end
    end

    // Storage write; flushed on reset so nothing stale survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr)
                r_drop_cnt <= 8'd1;
            else if (r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

`ifdef SUMFIFO_TOTAL_EN
    logic [W+7:0] r_total;

    // Running sum of everything handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_total <= '0;
        else if (w_pop)
            r_total <= r_total + (W+8)'(bus.out_data);
    end

    assign total = r_total;
`endif

    assign bus.out_valid = !r_empty;
    assign bus.out_data  = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign count         = r_count;
    assign full          = r_full;
    assign empty         = r_empty;
    assign overflow      = r_overflow;
    assign drop_cnt      = r_drop_cnt;
endmodule
